// File: rtl/tinker_mem_responder.sv
// Byte-addressed memory responder. It accepts one fetch, load or store at a
// time, moves one byte per cycle between the captured request and the byte
// array, and then presents a single response until the initiator takes it.
//
// Handshake rules, used by both channels: a transfer happens on a rising edge
// where valid && ready are both 1. The responder raises req_ready only in IDLE
// and resp_valid only in RESP. Once resp_valid is up, resp_data and resp_err
// stay fixed until the edge where resp_ready is also 1.
module tinker_mem_responder #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The byte array has no reset, so it keeps its contents across reset.
  logic [7:0]    mem_q [MEM_BYTES];

  state_t        state_q;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   data_q;
  logic          err_q;
  logic [3:0]    idx_q;

  logic [3:0]    req_n;
  logic [64:0]   req_end;
  logic          req_bad;
  logic [3:0]    cur_n;
  logic          xfer;
  logic          mem_we;
  logic [AW-1:0] byte_addr;
  logic [5:0]    byte_lane;

  // Decode the incoming request. The end address is formed at 65 bits so a
  // request near the top of the 64-bit space cannot wrap into range.
  always_comb begin
    req_n   = (req_op == OP_FETCH) ? 4'd4 : 4'd8;
    req_end = {1'b0, req_addr} + {61'd0, req_n};
    req_bad = (req_op == OP_RSVD) || (req_end > 65'(MEM_BYTES));
  end

  // Byte-transfer datapath for the captured request. Only the low address
  // bits are kept: an accepted in-range request always fits in them, and an
  // error request never touches the array.
  always_comb begin
    cur_n     = (op_q == OP_FETCH) ? 4'd4 : 4'd8;
    xfer      = (state_q == ACCESS) && !err_q && (idx_q != cur_n);
    mem_we    = xfer && (op_q == OP_STORE) && !reset;
    byte_addr = addr_q + AW'(idx_q);
    byte_lane = {idx_q[2:0], 3'b000};
  end

  // Control FSM with registered response fields. ACCESS moves byte i on the
  // edge where idx_q == i, then spends one more edge handing over to RESP.
  // An error request spends exactly one edge in ACCESS and moves no bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_bad;
            data_q  <= 64'd0;
            idx_q   <= 4'd0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (xfer) begin
            if (op_q != OP_STORE) begin
              data_q[byte_lane +: 8] <= mem_q[byte_addr];
            end
            idx_q <= idx_q + 4'd1;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store path: one byte per ACCESS cycle. Reset blocks the write on the edge
  // where it is asserted, so an aborted store keeps only the earlier bytes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[byte_addr] <= wdata_q[byte_lane +: 8];
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_data   = data_q;
  assign resp_err    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Self-checking bench for tinker_mem_responder: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic checked against a
// byte-array reference model.
module tb_tinker_mem_responder;

  localparam int MEM_BYTES = 4096;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [1:0]  dbg_state_o;

  tinker_mem_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and monitor ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int acc_cnt = 0;
  int acc_cyc_q[$];
  int hs_cyc_q[$];
  logic [63:0] hs_data_q[$];
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready) begin
      acc_cnt++;
      acc_cyc_q.push_back(cyc);
    end
    if (!reset && resp_valid && resp_ready) begin
      hs_cnt++;
      hs_cyc_q.push_back(cyc);
      hs_data_q.push_back(resp_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The memory as a plain byte array; a request is judged by its byte range.
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic void model_req(input logic [1:0] op, input logic [63:0] addr,
                                    input logic [63:0] wdata, output logic [63:0] data,
                                    output logic err, output int lat);
    int n;
    n    = (op == 2'b00) ? 4 : 8;
    err  = (op == 2'b11) || (({1'b0, addr} + 65'(n)) > 65'(MEM_BYTES));
    data = 64'd0;
    lat  = err ? 1 : n + 1;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (op == 2'b10) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        else data[8*i +: 8] = ref_mem[int'(addr) + i];
      end
    end
  endfunction

  // ---------------- driver ----------------
  // Issues one request from an idle point (#1 after an edge), scrambles the
  // request inputs after acceptance, measures edges from accept to resp_valid,
  // holds resp_ready low for 'hold' cycles, then completes the handshake.
  task automatic do_req(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                        input int hold, output logic [63:0] data, output logic err,
                        output int lat, output bit tmo);
    int w;
    tmo = 1'b0;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid) tmo = 1'b1;
    data = resp_data;
    err  = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_data,
                           input logic exp_err, input int exp_lat, input int hold);
    logic [63:0] d;
    logic e;
    int l;
    bit t;
    do_req(op, addr, wdata, hold, d, e, l, t);
    check({tag, " timeout"}, 64'(t), 64'd0);
    check({tag, " data"}, d, exp_data);
    check({tag, " err"}, 64'(e), 64'(exp_err));
    check({tag, " latency"}, 64'(l), 64'(exp_lat));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  initial begin
    logic [63:0] md, d0;
    logic me;
    int ml, w;
    int h0, a0, hb, ab, k;
    logic [63:0] b2b_addr [3];

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 64'd0;
    req_wdata = 64'd0; resp_ready = 1'b0;

    vecs[0]  = '{2'b10, 64'h100, 64'h8877665544332211, 64'h0, 1'b0, 9};
    vecs[1]  = '{2'b01, 64'h100, 64'h0, 64'h8877665544332211, 1'b0, 9};
    vecs[2]  = '{2'b00, 64'h104, 64'h0, 64'h0000000088776655, 1'b0, 5};
    vecs[3]  = '{2'b10, 64'hFF8, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 9};
    vecs[4]  = '{2'b01, 64'hFF8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9};
    vecs[5]  = '{2'b00, 64'hFFC, 64'h0, 64'h00000000DEADBEEF, 1'b0, 5};
    vecs[6]  = '{2'b01, 64'hFF9, 64'h0, 64'h0, 1'b1, 1};
    vecs[7]  = '{2'b01, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1, 1};
    vecs[8]  = '{2'b11, 64'h100, 64'h0, 64'h0, 1'b1, 1};
    vecs[9]  = '{2'b00, 64'hFFD, 64'h0, 64'h0, 1'b1, 1};
    vecs[10] = '{2'b10, 64'hFF9, 64'h1234, 64'h0, 1'b1, 1};
    vecs[11] = '{2'b01, 64'hFF8, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9};

    // ---- reset, with req_valid held during reset: nothing may be accepted
    req_valid = 1'b1; req_op = 2'b01; req_addr = 64'h100;
    repeat (3) @(posedge clk);
    #1;
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_err", 64'(resp_err), 64'd0);
    check("reset resp_data", resp_data, 64'd0);
    reset = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    check("post-reset req_ready", 64'(req_ready), 64'd1);
    check("post-reset resp_valid", 64'(resp_valid), 64'd0);
    check("post-reset accepts", 64'(acc_cnt), 64'd0);

    // ---- directed table
    for (int i = 0; i < NVEC; i++) begin
      model_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, md, me, ml);
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, i % 3);
    end

    // ---- backpressure: resp_ready low 5 cycles while req_* wiggle
    h0 = hs_cnt; a0 = acc_cnt;
    req_op = 2'b01; req_addr = 64'h100; req_valid = 1'b1;
    @(posedge clk); #1;
    w = 0;
    while (!resp_valid && w < 40) begin
      req_op = 2'($urandom); req_addr = {$urandom, $urandom};
      @(posedge clk); #1; w++;
    end
    check("bp resp_valid seen", 64'(resp_valid), 64'd1);
    d0 = resp_data;
    check("bp data", d0, 64'h8877665544332211);
    for (int c = 0; c < 5; c++) begin
      req_op = 2'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("bp hold%0d data", c), resp_data, d0);
      check($sformatf("bp hold%0d req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("bp hold%0d resp_valid", c), 64'(resp_valid), 64'd1);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp resp_valid drop", 64'(resp_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp handshakes", 64'(hs_cnt - h0), 64'd1);
    check("bp accepts", 64'(acc_cnt - a0), 64'd1);

    // ---- reset in the middle of a store
    model_req(2'b10, 64'h200, 64'h0, md, me, ml);
    run_check("ms preload", 2'b10, 64'h200, 64'h0, 64'h0, 1'b0, 9, 0);
    h0 = hs_cnt;
    req_op = 2'b10; req_addr = 64'h200; req_wdata = 64'hFFFFFFFFFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("ms resp_valid after reset", 64'(resp_valid), 64'd0);
    check("ms req_ready after reset", 64'(req_ready), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("ms no response", 64'(hs_cnt - h0), 64'd0);
    for (int i = 0; i < 3; i++) ref_mem[16'h200 + i] = 8'hFF;
    run_check("ms load", 2'b01, 64'h200, 64'h0, 64'h0000000000FFFFFF, 1'b0, 9, 0);

    // ---- preload the random window 0x300..0x33F
    for (int i = 0; i < 8; i++) begin
      logic [63:0] wd;
      wd = {$urandom, $urandom};
      model_req(2'b10, 64'h300 + 64'(8*i), wd, md, me, ml);
      run_check($sformatf("pre%0d", i), 2'b10, 64'h300 + 64'(8*i), wd, md, me, ml, 0);
    end

    // ---- back-to-back loads with req_valid held high
    b2b_addr[0] = 64'h300; b2b_addr[1] = 64'h30B; b2b_addr[2] = 64'h313;
    for (int i = 0; i < 3; i++) begin
      model_req(2'b01, b2b_addr[i], 64'h0, md, me, ml);
      exp_q.push_back(md);
    end
    ab = acc_cyc_q.size(); hb = hs_cyc_q.size();
    req_op = 2'b01; req_addr = b2b_addr[0]; req_valid = 1'b1; resp_ready = 1'b1;
    k = 0; w = 0;
    while (hs_cyc_q.size() < hb + 3 && w < 100) begin
      @(posedge clk); #1; w++;
      if (acc_cyc_q.size() > ab + k) begin
        k++;
        if (k < 3) req_addr = b2b_addr[k];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    check("b2b handshakes", 64'(hs_cyc_q.size() - hb), 64'd3);
    check("b2b accepts", 64'(acc_cyc_q.size() - ab), 64'd3);
    if (hs_cyc_q.size() >= hb + 3 && acc_cyc_q.size() >= ab + 3) begin
      for (int i = 1; i < 3; i++)
        check($sformatf("b2b accept%0d spacing", i), 64'(acc_cyc_q[ab + i]),
              64'(hs_cyc_q[hb + i - 1] + 1));
      for (int i = 0; i < 3; i++)
        check($sformatf("b2b data%0d", i), hs_data_q[hb + i], exp_q.pop_front());
    end
    exp_q.delete();
    @(posedge clk); #1;

    // ---- randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [1:0]  op;
      logic [63:0] addr, wd;
      int mode;
      mode = $urandom_range(0, 9);
      op   = 2'($urandom_range(0, 2));
      wd   = {$urandom, $urandom};
      if (mode < 6)       addr = 64'h300 + 64'($urandom_range(0, 56));
      else if (mode == 6) addr = 64'hFF9 + 64'($urandom_range(0, 6));
      else if (mode == 7) addr = {1'b1, 31'($urandom), $urandom};
      else if (mode == 8) begin op = 2'b11; addr = 64'h300; end
      else                addr = 64'(MEM_BYTES) + 64'($urandom_range(0, 100));
      if (mode == 6 && op == 2'b10) op = 2'b00;
      model_req(op, addr, wd, md, me, ml);
      run_check($sformatf("rnd%0d op%0d @%h", it, op, addr), op, addr, wd, md, me, ml,
                $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
